iter_divider: RTL
=================

Name: iter_divider

Overview:
- Parametrised multi-cycle restoring divider; next generation of the pipeline CPU's 32-bit unsigned divider.
- Adds a WIDTH generic, signed and unsigned modes, and a start/busy/done handshake.
- Flags divide-by-zero and produces a fixed, data-independent latency.
- Sits in the EX stage beside the multiplier; hazard logic stalls the pipe while busy=1 and captures dataOut when done=1.

Parameters:
- WIDTH, 32, operand width in bits (legal values 8..64, even).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00 = DIVU (unsigned), 01 = DIV (signed two's complement); 10/11 reserved.
- dataA  input  WIDTH  dividend; sampled only on the accepting edge.
- dataB  input  WIDTH  divisor; sampled only on the accepting edge.
- busy  output  1  high from the cycle after acceptance until done is asserted.
- done  output  1  one-cycle pulse; dataOut is valid from this cycle on.
- dataOut  output  2*WIDTH  {remainder, quotient}; remainder in the upper WIDTH bits.
- div_by_zero  output  1  registered with dataOut; 1 if the divisor was 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, dataOut=0, div_by_zero=0, counter=0.
- Reset wins over every other input, including mid-operation; the operation in flight is discarded with no done.
- States: IDLE, RUN, FIX.
- IDLE:
  - Accept when start=1 and op is 00 or 01.
  - On acceptance, latch |A|, |B|, the quotient sign (A[msb]^B[msb]) & signed, the remainder sign A[msb] & signed, and zero=(B==0).
  - Then load the partial remainder with {WIDTH'0, |A|}, clear the counter and go to RUN. busy=1 from the next cycle.
  - start with op 10/11 is ignored: no busy, no done.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left by 1; trial = rem_hi - |B| (WIDTH+1 bits).
  - If the trial is non-negative: rem_hi = trial and quotient LSB = 1; otherwise keep rem_hi and quotient LSB = 0.
  - After WIDTH steps go to FIX.
- FIX: one cycle.
  - Quotient is negated if its sign is set; remainder is negated if its sign is set.
  - If zero=1, the result is forced to quotient = all ones and remainder = the original dataA.
  - dataOut and div_by_zero are registered, done=1 and busy=0 in the following cycle, and the state returns to IDLE.
- Latency: the start cycle is cycle 0; done is high in cycle WIDTH+2 (34 for WIDTH=32).
  - Latency is constant for all operands, including divide-by-zero.
- Signed rules:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MIN / -1 gives quotient = MIN and remainder = 0, with no flag.
- start while busy=1 or done=1 is ignored. A new start is accepted in the cycle after done (back-to-back capable).
- dataOut and div_by_zero hold their last result until the next done or a reset.
- The |A| and |B| magnitudes are computed as WIDTH-bit unsigned values, so |MIN| = 2^(WIDTH-1) is exact.

Decomposition:
- Package div_pkg:
  - op encodings OP_DIVU=2'b00 and OP_DIV=2'b01;
  - state enum {S_IDLE, S_RUN, S_FIX};
  - a function for the two's-complement conditional negate.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem_hi, quo, divisor. Outputs: next rem_hi, next quo.
  - Lets a later version unroll 2 steps per cycle by instantiating it twice.

Test Plan:
- DIVU, WIDTH=32, A=100, B=7, start for 1 cycle -> done in cycle 34, dataOut={32'd2, 32'd14}, div_by_zero=0, busy high in cycles 1..33.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also A=7, B=-2 -> quotient=-3, remainder=1.
- DIVU with B=0, A=0x12345678 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, done still in cycle 34.
- DIV, A=0x80000000, B=0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
- Handshake:
  - start held high for 40 cycles with changing operands -> exactly one result per 35-cycle window, using the operands present in each accepting cycle;
  - op=2'b10 with start -> busy stays 0 and no done.
- Reset asserted in cycle 10 of a run -> next cycle busy=0, done=0, dataOut=0. A new start afterwards completes normally. Repeat the directed cases at WIDTH=8 (latency 10).

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the iterative restoring divider:
//                operation encodings, FSM state type and a conditional
//                two's-complement negate helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Operation encodings; 2'b10 and 2'b11 are reserved and never accepted
  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  // Widest operand the helper below handles; callers resize to their WIDTH
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Two's-complement negate when neg is set. Operates at MAX_W bits; the low
  // WIDTH bits of the result are the correct WIDTH-bit negation, so callers
  // zero-extend on the way in and truncate on the way out.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                input logic             neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step. Shifts the
//                {rem_hi, quo} pair left by one and subtracts the divisor
//                from the upper half when the result stays non-negative.
//                Kept separate so two copies can be chained for a 2-bit/cycle
//                variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_hi_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_hi_o,
  output logic [WIDTH-1:0] quo_o
);

  // rem_hi is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  assign shifted = {rem_hi_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};
  assign fits    = ~trial[WIDTH];

  assign rem_hi_o = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_o    = {quo_i[WIDTH-2:0], fits};

endmodule : div_step
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider
//  Description : Multi-cycle restoring divider, signed/unsigned, with a
//                start/busy/done handshake and divide-by-zero flag. Latency
//                is fixed at WIDTH+2 cycles from the accepting cycle to done.
//                dataOut = {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   rem_q,   rem_d;    // partial remainder (upper half)
  logic [WIDTH-1:0]   quo_q,   quo_d;    // dividend shifting out / quotient in
  logic [WIDTH-1:0]   div_q,   div_d;    // |divisor|
  logic [WIDTH-1:0]   a_q,     a_d;      // original dividend for div-by-zero
  logic               qneg_q,  qneg_d;
  logic               rneg_q,  rneg_d;
  logic               zero_q,  zero_d;
  logic               done_q,  done_d;
  logic [2*WIDTH-1:0] dout_q,  dout_d;
  logic               dbz_q,   dbz_d;

  logic               op_valid;
  logic               is_signed;
  logic               accept;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign op_valid  = (op == OP_DIVU) || (op == OP_DIV);
  assign is_signed = (op == OP_DIV);
  // done_q high means this is the result cycle, where a new start is ignored
  assign accept    = start && op_valid && !done_q;

  // Magnitudes are unsigned WIDTH-bit, so |MIN| = 2^(WIDTH-1) stays exact
  assign abs_a = WIDTH'(cond_neg(64'(dataA), is_signed & dataA[WIDTH-1]));
  assign abs_b = WIDTH'(cond_neg(64'(dataB), is_signed & dataB[WIDTH-1]));

  assign q_fix = WIDTH'(cond_neg(64'(quo_q), qneg_q));
  assign r_fix = WIDTH'(cond_neg(64'(rem_q), rneg_q));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_hi_i  (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_hi_o  (step_rem),
    .quo_o     (step_quo)
  );

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state: accept in IDLE, one restoring step per RUN cycle, sign fix-up
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = dataA;
          div_d   = abs_b;
          rem_d   = '0;
          quo_d   = abs_a;
          qneg_d  = (dataA[WIDTH-1] ^ dataB[WIDTH-1]) & is_signed;
          rneg_d  = dataA[WIDTH-1] & is_signed;
          zero_d  = (dataB == '0);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Divide-by-zero result is forced regardless of the iteration outcome
        if (zero_q) begin
          dout_d = {a_q, {WIDTH{1'b1}}};
        end else begin
          dout_d = {r_fix, q_fix};
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dataOut     = dout_q;
  assign div_by_zero = dbz_q;

endmodule : iter_divider
`default_nettype wire
